// File: rtl/inst_data_sram_arbiter.sv
// rtl/inst_data_sram_arbiter.sv - shares one single-port SRAM between fetch and data requesters
module inst_data_sram_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [XLEN-1:0] i_rdata,
  input  logic            d_req,
  input  logic [3:0]      d_wen,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            sram_en,
  output logic [3:0]      sram_wen,
  output logic [XLEN-1:0] sram_addr,
  output logic [XLEN-1:0] sram_wdata,
  input  logic [XLEN-1:0] sram_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, RESP_I, RESP_D} resp_st_t;

  resp_st_t   resp_st;
  logic [3:0] starve_cnt;
  logic       force_i;

  // Data normally wins; fetch wins once it has been denied STARVE_MAX cycles in a row.
  always_comb begin
    force_i    = i_req && (starve_cnt == STARVE_LIM);
    d_gnt      = d_req && !force_i;
    i_gnt      = i_req && (!d_req || force_i);
    sram_en    = i_gnt | d_gnt;
    sram_wen   = d_gnt ? d_wen : 4'b0000;
    sram_wdata = d_wdata;
    sram_addr  = '0;
    if (i_gnt) begin
      sram_addr = i_addr;
    end else if (d_gnt) begin
      sram_addr = d_addr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= 4'd0;
    end else if (!i_req || i_gnt) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Remembers who owns the read data that the SRAM returns next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_st <= IDLE;
    end else if (i_gnt) begin
      resp_st <= RESP_I;
    end else if (d_gnt && (d_wen == 4'b0000)) begin
      resp_st <= RESP_D;
    end else begin
      resp_st <= IDLE;
    end
  end

  assign i_rvalid = (resp_st == RESP_I);
  assign d_rvalid = (resp_st == RESP_D);
  assign i_rdata  = sram_rdata;
  assign d_rdata  = sram_rdata;

endmodule

// File: tb/tb_inst_data_sram_arbiter.sv
// tb/tb_inst_data_sram_arbiter.sv - table-driven bench for inst_data_sram_arbiter
module tb_inst_data_sram_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [3:0]  d_wen;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  int checks;
  int errors;

  inst_data_sram_arbiter #(.XLEN(32), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM: word at byte address a holds 0xC0DE0000|a, except 0x100 holds 0x11223344.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (!reset) begin
      for (int w = 0; w < 256; w++) mem[w] <= 32'hC0DE_0000 | (w * 4);
      mem[64] <= 32'h1122_3344;
    end else if (sram_en) begin
      if (sram_wen == 4'b0000) begin
        sram_rdata <= mem[sram_addr[9:2]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (sram_wen[b]) mem[sram_addr[9:2]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end
    end
  end

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic [3:0]  dw;
    logic [31:0] da;
    logic [31:0] dd;
    logic        eig;
    logic        edg;
    logic        eiv;
    logic        edv;
    logic [31:0] erd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic [3:0] dw,
                              logic [31:0] da, logic [31:0] dd, logic eig, logic edg,
                              logic eiv, logic edv, logic [31:0] erd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.eig = eig; v.edg = edg; v.eiv = eiv; v.edv = edv; v.erd = erd;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d actual %h required %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd);
    i_req = ir; i_addr = ia; d_req = dr; d_wen = dw; d_addr = da; d_wdata = dd;
  endtask

  initial begin
    vec_t v;
    logic [31:0] exp_addr;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_i_rvalid", -1, 32'(i_rvalid), 32'd0);
    chk("rst_d_rvalid", -1, 32'(d_rvalid), 32'd0);
    chk("rst_sram_en", -1, 32'(sram_en), 32'd0);
    reset = 1'b1;

    // Reset lands while a fetch read is outstanding.
    @(negedge clk);
    drive(1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1 chk("r1_i_gnt", -1, 32'(i_gnt), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1 chk("r1_i_rvalid_in_reset", -1, 32'(i_rvalid), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("r1_i_rvalid_after", -1, 32'(i_rvalid), 32'd0);
    chk("r1_d_rvalid_after", -1, 32'(d_rvalid), 32'd0);

    // Build starvation up to 3, then reset with a data read outstanding.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, 32'h10, 1'b1, 4'h0, 32'h40, 32'h0);
      #1;
      chk("r2_d_gnt", k, 32'(d_gnt), 32'd1);
      chk("r2_i_gnt", k, 32'(i_gnt), 32'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1 chk("r2_d_rvalid_in_reset", -1, 32'(d_rvalid), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("r2_d_rvalid_after", -1, 32'(d_rvalid), 32'd0);
    chk("r2_i_rvalid_after", -1, 32'(i_rvalid), 32'd0);
    // A cleared counter means four data wins before fetch is forced.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1'b1, 32'h10, 1'b1, 4'h0, 32'h40, 32'h0);
      #1;
      chk("r2_post_i_gnt", k, 32'(i_gnt), (k == 4) ? 32'd1 : 32'd0);
      chk("r2_post_d_gnt", k, 32'(d_gnt), (k == 4) ? 32'd0 : 32'd1);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Fetch only
    vecs.push_back(mk(1, 32'h0,  0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 32'h4,  0, 4'h0, 32'h0, 32'h0, 1, 0, 1, 0, 32'hC0DE_0000));
    vecs.push_back(mk(1, 32'h8,  0, 4'h0, 32'h0, 32'h0, 1, 0, 1, 0, 32'hC0DE_0004));
    vecs.push_back(mk(0, 32'h0,  0, 4'h0, 32'h0, 32'h0, 0, 0, 1, 0, 32'hC0DE_0008));
    // Contention: D,D,D,D,I,D,D,D,D,I
    vecs.push_back(mk(1, 32'h10, 1, 4'h0, 32'h40, 32'h0, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 32'h10, 1, 4'h0, 32'h40, 32'h0, 0, 1, 0, 1, 32'hC0DE_0040));
    vecs.push_back(mk(1, 32'h10, 1, 4'h0, 32'h40, 32'h0, 0, 1, 0, 1, 32'hC0DE_0040));
    vecs.push_back(mk(1, 32'h10, 1, 4'h0, 32'h40, 32'h0, 0, 1, 0, 1, 32'hC0DE_0040));
    vecs.push_back(mk(1, 32'h10, 1, 4'h0, 32'h40, 32'h0, 1, 0, 0, 1, 32'hC0DE_0040));
    vecs.push_back(mk(1, 32'h10, 1, 4'h0, 32'h40, 32'h0, 0, 1, 1, 0, 32'hC0DE_0010));
    vecs.push_back(mk(1, 32'h10, 1, 4'h0, 32'h40, 32'h0, 0, 1, 0, 1, 32'hC0DE_0040));
    vecs.push_back(mk(1, 32'h10, 1, 4'h0, 32'h40, 32'h0, 0, 1, 0, 1, 32'hC0DE_0040));
    vecs.push_back(mk(1, 32'h10, 1, 4'h0, 32'h40, 32'h0, 0, 1, 0, 1, 32'hC0DE_0040));
    vecs.push_back(mk(1, 32'h10, 1, 4'h0, 32'h40, 32'h0, 1, 0, 0, 1, 32'hC0DE_0040));
    vecs.push_back(mk(0, 32'h0,  0, 4'h0, 32'h0,  32'h0, 0, 0, 1, 0, 32'hC0DE_0010));
    // Partial write then read back
    vecs.push_back(mk(0, 32'h0, 1, 4'b0011, 32'h100, 32'hAABB_CCDD, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0, 1, 4'b0000, 32'h100, 32'h0,         0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0, 0, 4'b0000, 32'h0,   32'h0,         0, 0, 0, 1, 32'h1122_CCDD));
    // Back-to-back owner switch
    vecs.push_back(mk(1, 32'h20, 0, 4'h0, 32'h0,  32'h0, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,  1, 4'h0, 32'h40, 32'h0, 0, 1, 1, 0, 32'hC0DE_0020));
    vecs.push_back(mk(1, 32'h24, 0, 4'h0, 32'h0,  32'h0, 1, 0, 0, 1, 32'hC0DE_0040));
    vecs.push_back(mk(0, 32'h0,  0, 4'h0, 32'h0,  32'h0, 0, 0, 1, 0, 32'hC0DE_0024));
    // Starvation count restarts after fetch drops its request
    vecs.push_back(mk(1, 32'h10, 1, 4'h0, 32'h40, 32'h0, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 32'h10, 1, 4'h0, 32'h40, 32'h0, 0, 1, 0, 1, 32'hC0DE_0040));
    vecs.push_back(mk(1, 32'h10, 1, 4'h0, 32'h40, 32'h0, 0, 1, 0, 1, 32'hC0DE_0040));
    vecs.push_back(mk(0, 32'h0,  1, 4'h0, 32'h40, 32'h0, 0, 1, 0, 1, 32'hC0DE_0040));
    vecs.push_back(mk(1, 32'h10, 1, 4'h0, 32'h40, 32'h0, 0, 1, 0, 1, 32'hC0DE_0040));
    vecs.push_back(mk(1, 32'h10, 1, 4'h0, 32'h40, 32'h0, 0, 1, 0, 1, 32'hC0DE_0040));
    vecs.push_back(mk(1, 32'h10, 1, 4'h0, 32'h40, 32'h0, 0, 1, 0, 1, 32'hC0DE_0040));
    vecs.push_back(mk(1, 32'h10, 1, 4'h0, 32'h40, 32'h0, 0, 1, 0, 1, 32'hC0DE_0040));
    vecs.push_back(mk(1, 32'h10, 1, 4'h0, 32'h40, 32'h0, 1, 0, 0, 1, 32'hC0DE_0040));
    vecs.push_back(mk(0, 32'h0,  0, 4'h0, 32'h0,  32'h0, 0, 0, 1, 0, 32'hC0DE_0010));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      drive(v.ir, v.ia, v.dr, v.dw, v.da, v.dd);
      #1;
      exp_addr = v.eig ? v.ia : (v.edg ? v.da : 32'h0);
      chk("i_gnt", i, 32'(i_gnt), 32'(v.eig));
      chk("d_gnt", i, 32'(d_gnt), 32'(v.edg));
      chk("i_rvalid", i, 32'(i_rvalid), 32'(v.eiv));
      chk("d_rvalid", i, 32'(d_rvalid), 32'(v.edv));
      chk("sram_en", i, 32'(sram_en), 32'(v.eig | v.edg));
      chk("sram_addr", i, sram_addr, exp_addr);
      chk("sram_wen", i, 32'(sram_wen), v.edg ? 32'(v.dw) : 32'd0);
      if (v.eiv) chk("i_rdata", i, i_rdata, v.erd);
      if (v.edv) chk("d_rdata", i, d_rdata, v.erd);
    end

    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
